// File: rtl/synth_pkg.sv
// Shared types and helpers for the poly synth mixer: waveform codes, noise LFSR
// constants and the signed saturation helper.
package synth_pkg;

    typedef enum logic [2:0] {
        SQUARE = 3'd0,
        SAW    = 3'd1,
        TRI    = 3'd2,
        PULSE  = 3'd3,
        NOISE  = 3'd4
    } wave_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Clamp x into the signed range of a w-bit two's complement value (w <= 63).
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi)
            sat_signed = hi;
        else if (x < lo)
            sat_signed = lo;
        else
            sat_signed = x;
    endfunction

endpackage

// File: rtl/synth_wavegen.sv
// Combinational waveform generator (S1): phase + waveform code -> signed sample.
// The noise input and NOISE code exist only when SYNTH_NOISE_EN is defined.
module synth_wavegen
    import synth_pkg::*;
#(
    parameter int PHASE_W  = 32,
    parameter int SAMPLE_W = 16
) (
    input  logic [PHASE_W-1:0]         phase,
    input  logic [2:0]                 wave_sel,
    input  logic [7:0]                 duty,
`ifdef SYNTH_NOISE_EN
    input  logic [15:0]                noise,
`endif
    output logic signed [SAMPLE_W-1:0] sample
);

    localparam logic signed [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic                m;
    logic [SAMPLE_W-1:0] p;
    logic [SAMPLE_W-1:0] t;
    logic [SAMPLE_W-1:0] tf;
    logic                unused_bits;

    assign m  = phase[PHASE_W-1];
    assign p  = phase[PHASE_W-1 -: SAMPLE_W];
    assign t  = phase[PHASE_W-2 -: SAMPLE_W];
    // Folding the lower ramp on the upper half of the cycle gives the triangle.
    assign tf = m ? ~t : t;

`ifdef SYNTH_NOISE_EN
    assign unused_bits = ^{phase, noise};
`else
    assign unused_bits = ^phase;
`endif

    always_comb begin
        sample = '0;
        case (wave_e'(wave_sel))
            SQUARE: sample = m ? S_MIN : S_MAX;
            SAW:    sample = {~p[SAMPLE_W-1], p[SAMPLE_W-2:0]};
            TRI:    sample = {~tf[SAMPLE_W-1], tf[SAMPLE_W-2:0]};
            PULSE:  sample = (phase[PHASE_W-1 -: 8] < duty) ? S_MAX : S_MIN;
`ifdef SYNTH_NOISE_EN
            NOISE:  sample = SAMPLE_W'($signed(noise));
`endif
            default: sample = '0;
        endcase
    end

endmodule

// File: rtl/poly_synth_mixer.sv
// Time-multiplexed polyphonic oscillator/mixer: one voice per clock through a
// 4-stage pipeline, saturated mix per frame. Optional noise via SYNTH_NOISE_EN.
module poly_synth_mixer
    import synth_pkg::*;
#(
    parameter int N_VOICES = 8,
    parameter int PHASE_W  = 32,
    parameter int SAMPLE_W = 16,
    parameter int VOL_W    = 16,
    parameter int OUT_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sample_tick,
    input  logic [N_VOICES*PHASE_W-1:0]  phase_inc,
    input  logic [N_VOICES*3-1:0]        wave_sel,
    input  logic [N_VOICES*8-1:0]        duty,
    input  logic [N_VOICES*VOL_W-1:0]    volume,
    input  logic [N_VOICES-1:0]          gate,
    input  logic                         clear_overrun,
    output logic signed [OUT_W-1:0]      out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         clip,
    output logic                         overrun
);

    localparam int VIDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int ACC_W  = SAMPLE_W + $clog2(N_VOICES);
    localparam int PROD_W = SAMPLE_W + VOL_W + 1;
    localparam logic [VIDX_W-1:0] LAST_V = VIDX_W'(N_VOICES - 1);

    logic [PHASE_W-1:0] phase_q [N_VOICES];

    logic              iss_q;
    logic [VIDX_W-1:0] cnt_q;
    logic              start;

    logic                       vld_p0, vld_p1, vld_p2, vld_p3;
    logic [VIDX_W-1:0]          v_p0, v_p1, v_p2, v_p3;
    logic [PHASE_W-1:0]         phase_p1;
    logic signed [SAMPLE_W-1:0] samp_p1, samp_p2;
    logic [VOL_W-1:0]           vol_p2;
    logic signed [PROD_W-1:0]   samp_x_p2, vol_x_p2, prod_p2;
    logic signed [SAMPLE_W-1:0] scaled_p2, scaled_p3;
    logic signed [ACC_W-1:0]    acc_q, acc_next;
    logic signed [63:0]         acc_ext, acc_sat;

    assign start  = sample_tick & ~busy;
    // Voice 0 issues in the tick cycle itself; the rest follow from the counter.
    assign vld_p0 = start | iss_q;
    assign v_p0   = iss_q ? cnt_q : '0;

`ifdef SYNTH_NOISE_EN
    logic [15:0] lfsr_q;
    logic [15:0] noise_frm;

    always_ff @(posedge clk) begin
        if (!reset_n)
            lfsr_q <= LFSR_SEED;
        else if (start)
            lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    end

    // The whole frame sees the pre-advance value, so the first frame uses the seed.
    always_ff @(posedge clk) begin
        if (start)
            noise_frm <= lfsr_q;
    end
`endif

    synth_wavegen #(
        .PHASE_W  (PHASE_W),
        .SAMPLE_W (SAMPLE_W)
    ) u_wavegen (
        .phase    (phase_p1),
        .wave_sel (wave_sel[v_p1*3 +: 3]),
        .duty     (duty[v_p1*8 +: 8]),
`ifdef SYNTH_NOISE_EN
        .noise    (noise_frm),
`endif
        .sample   (samp_p1)
    );

    // S1 write-back: gated-off voices are parked at phase 0 for a hard restart.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_VOICES; i++)
                phase_q[i] <= '0;
        end else if (vld_p1) begin
            phase_q[v_p1] <= gate[v_p1] ? (phase_p1 + phase_inc[v_p1*PHASE_W +: PHASE_W]) : '0;
        end
    end

    assign samp_x_p2 = PROD_W'(samp_p2);
    assign vol_x_p2  = PROD_W'({1'b0, vol_p2});
    assign prod_p2   = samp_x_p2 * vol_x_p2;
    assign scaled_p2 = SAMPLE_W'(prod_p2 >>> VOL_W);

    assign acc_next = ((v_p3 == '0) ? ACC_W'(0) : acc_q) + ACC_W'(scaled_p3);
    assign acc_ext  = 64'(acc_next);
    assign acc_sat  = sat_signed(acc_ext, OUT_W);

    always_ff @(posedge clk) begin
        // S0 -> S1: phase read
        phase_p1  <= phase_q[v_p0];
        v_p1      <= v_p0;
        // S1 -> S2: waveform, gate and volume
        samp_p2   <= gate[v_p1] ? samp_p1 : '0;
        vol_p2    <= volume[v_p1*VOL_W +: VOL_W];
        v_p2      <= v_p1;
        // S2 -> S3: scaled product
        scaled_p3 <= scaled_p2;
        v_p3      <= v_p2;
        // S3: accumulate
        if (vld_p3)
            acc_q <= acc_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            iss_q     <= 1'b0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            vld_p3    <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            vld_p1    <= vld_p0;
            vld_p2    <= vld_p1;
            vld_p3    <= vld_p2;
            if (start) begin
                busy  <= 1'b1;
                iss_q <= 1'b1;
                cnt_q <= VIDX_W'(1);
            end else if (iss_q) begin
                cnt_q <= cnt_q + VIDX_W'(1);
                if (cnt_q == LAST_V)
                    iss_q <= 1'b0;
            end
            if (vld_p3 && v_p3 == LAST_V) begin
                out       <= OUT_W'(acc_sat);
                clip      <= (acc_sat != acc_ext);
                out_valid <= 1'b1;
                busy      <= 1'b0;
            end
            if (sample_tick && busy)
                overrun <= 1'b1;
            else if (clear_overrun)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_poly_synth_mixer.sv
// Directed scoreboard bench for poly_synth_mixer (default parameters, N=8).
// Noise expectations follow SYNTH_NOISE_EN when the bench is built with it.
module tb_poly_synth_mixer;

    localparam int N  = 8;
    localparam int PW = 32;
    localparam int SW = 16;
    localparam int VW = 16;
    localparam int OW = 16;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 sample_tick = 1'b0;
    logic [N*PW-1:0]      phase_inc = '0;
    logic [N*3-1:0]       wave_sel = '0;
    logic [N*8-1:0]       duty = '0;
    logic [N*VW-1:0]      volume = '0;
    logic [N-1:0]         gate = '0;
    logic                 clear_overrun = 1'b0;
    logic signed [OW-1:0] out;
    logic                 out_valid;
    logic                 busy;
    logic                 clip;
    logic                 overrun;

    typedef struct {
        longint o;
        logic   c;
    } exp_t;

    exp_t   sb_q[$];
    int     n_vec = 0;
    int     n_err = 0;

    poly_synth_mixer #(
        .N_VOICES (N),
        .PHASE_W  (PW),
        .SAMPLE_W (SW),
        .VOL_W    (VW),
        .OUT_W    (OW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_tick   (sample_tick),
        .phase_inc     (phase_inc),
        .wave_sel      (wave_sel),
        .duty          (duty),
        .volume        (volume),
        .gate          (gate),
        .clear_overrun (clear_overrun),
        .out           (out),
        .out_valid     (out_valid),
        .busy          (busy),
        .clip          (clip),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_voice(input int v, input logic [2:0] w, input logic [31:0] inc,
                             input logic [15:0] vol, input logic [7:0] d, input logic g);
        wave_sel[v*3 +: 3]    = w;
        phase_inc[v*PW +: PW] = inc;
        volume[v*VW +: VW]    = vol;
        duty[v*8 +: 8]        = d;
        gate[v]               = g;
    endtask

    task automatic clear_all();
        phase_inc = '0;
        wave_sel  = '0;
        duty      = '0;
        volume    = '0;
        gate      = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // One frame: push expectation, tick, wait (bounded) for out_valid, compare.
    task automatic run_frame(input longint eo, input logic ec, input string tag);
        int   lat;
        exp_t e;
        sb_q.push_back('{o: eo, c: ec});
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        chk({tag, "_busy_hi"}, longint'(busy), 1);
        lat = 1;
        while (!out_valid && lat < 30) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, lat, 11);
        e = sb_q.pop_front();
        chk({tag, "_out"}, longint'(out), e.o);
        chk({tag, "_clip"}, longint'(clip), longint'(e.c));
        chk({tag, "_busy_lo"}, longint'(busy), 0);
        step();
        chk({tag, "_pulse"}, longint'(out_valid), 0);
        chk({tag, "_hold"}, longint'(out), e.o);
        step();
    endtask

    initial begin
        int   lat;
        int   pulses;
        int   first_lat;
        longint seen_out;
        exp_t e;

        do_reset();
        chk("rst_out", longint'(out), 0);
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_clip", longint'(clip), 0);
        chk("rst_overrun", longint'(overrun), 0);

        // Single square voice at half volume, quarter-cycle steps.
        set_voice(0, 3'd0, 32'h4000_0000, 16'h8000, 8'd0, 1'b1);
        run_frame(16383, 1'b0, "sq_f0");
        run_frame(16383, 1'b0, "sq_f1");
        run_frame(-16384, 1'b0, "sq_f2");
        run_frame(-16384, 1'b0, "sq_f3");

        // All voices full-scale square: positive then negative saturation.
        do_reset();
        for (int v = 0; v < N; v++)
            set_voice(v, 3'd0, 32'h8000_0000, 16'hFFFF, 8'd0, 1'b1);
        run_frame(32767, 1'b1, "sat_pos");
        run_frame(-32768, 1'b1, "sat_neg");

        do_reset();
        clear_all();
        set_voice(0, 3'd1, 32'h1000_0000, 16'hFFFF, 8'd0, 1'b1);
        run_frame(-32768, 1'b0, "saw_f0");
        run_frame(-28672, 1'b0, "saw_f1");

        do_reset();
        set_voice(0, 3'd2, 32'h4000_0000, 16'hFFFF, 8'd0, 1'b1);
        run_frame(-32768, 1'b0, "tri_f0");
        run_frame(0, 1'b0, "tri_f1");
        run_frame(32766, 1'b0, "tri_f2");

        do_reset();
        set_voice(0, 3'd3, 32'h4000_0000, 16'hFFFF, 8'h80, 1'b1);
        run_frame(32766, 1'b0, "pul_f0");
        run_frame(32766, 1'b0, "pul_f1");
        run_frame(-32768, 1'b0, "pul_f2");
        set_voice(0, 3'd3, 32'h4000_0000, 16'hFFFF, 8'h00, 1'b1);
        run_frame(-32768, 1'b0, "pul_duty0");

        // Second tick three cycles into a frame is dropped and flags overrun.
        do_reset();
        clear_all();
        set_voice(0, 3'd0, 32'h0, 16'h8000, 8'd0, 1'b1);
        sb_q.push_back('{o: 16383, c: 1'b0});
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        lat = 4;
        pulses = 0;
        first_lat = 0;
        seen_out = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) begin
                pulses++;
                if (first_lat == 0) begin
                    first_lat = lat;
                    seen_out = longint'(out);
                end
            end
            step();
            lat++;
        end
        e = sb_q.pop_front();
        chk("ovr_pulses", pulses, 1);
        chk("ovr_latency", first_lat, 11);
        chk("ovr_out", seen_out, e.o);
        chk("ovr_flag", longint'(overrun), 1);

        // Set and clear in the same cycle: set wins.
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        sample_tick = 1'b1;
        clear_overrun = 1'b1;
        step();
        sample_tick = 1'b0;
        clear_overrun = 1'b0;
        chk("ovr_set_wins", longint'(overrun), 1);
        lat = 0;
        while (busy && lat < 30) begin
            step();
            lat++;
        end
        chk("ovr_drain", longint'(busy), 0);
        step();

        // Gate: off frame parks phase at 0, restart resumes from 0.
        set_voice(0, 3'd0, 32'h4000_0000, 16'h8000, 8'd0, 1'b0);
        run_frame(0, 1'b0, "gate_off0");
        gate[0] = 1'b1;
        run_frame(16383, 1'b0, "gate_f0");
        run_frame(16383, 1'b0, "gate_f1");
        run_frame(-16384, 1'b0, "gate_f2");
        gate[0] = 1'b0;
        run_frame(0, 1'b0, "gate_off1");
        gate[0] = 1'b1;
        run_frame(16383, 1'b0, "gate_restart");

        // Reset five cycles into a frame aborts it.
        chk("abort_pre_ovr", longint'(overrun), 1);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        for (int i = 0; i < 4; i++)
            step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("abort_out", longint'(out), 0);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_clip", longint'(clip), 0);
        chk("abort_overrun", longint'(overrun), 0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid)
                pulses++;
            step();
        end
        chk("abort_no_valid", pulses, 0);

        // Code 4: noise from the seed when enabled, silent otherwise.
        do_reset();
        clear_all();
        set_voice(0, 3'd4, 32'h0100_0000, 16'hFFFF, 8'd0, 1'b1);
        set_voice(1, 3'd0, 32'h0, 16'h8000, 8'd0, 1'b1);
`ifdef SYNTH_NOISE_EN
        run_frame(-21279 + 16383, 1'b0, "noise_seed");
`else
        run_frame(16383, 1'b0, "noise_off");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
